branch_seq_unit: RTL
====================

# branch_seq_unit

Multi-cycle branch sequencer for the LEGv8 datapath that replaces the single-state CBZ/CBNZ decoder. It owns its own state register and accepts one branch instruction per start handshake. It resolves CBZ, CBNZ, B.cond, B, BL and BR over 2–3 cycles and drives the 29-bit datapath control word and the K constant each cycle. CBZ/CBNZ test the real register value through the ALU zero flag instead of the stale status Z; BL gets an explicit link-write cycle.

## Interface
- DATA_WIDTH, 64, width of K and of the datapath
- CNT_WIDTH, 16, width of each statistics counter
- clock  in  1  single clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- instruction  in  32  branch instruction; latched on an accepted start
- status  in  4  {V,C,Z,N}; latched on an accepted start
- alu_zero  in  1  ALU result-zero flag; sampled at the end of EVAL
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse in the BRANCH state
- branch_taken  out  1  valid while done is high
- illegal  out  1  valid while done is high; latched instruction is not a branch
- controlWord  out  29  {Psel[1:0],DA,SA,SB,Fsel,regW,ramW,Dsel[1:0],Bsel,PCsel,SL}
- K  out  DATA_WIDTH  sign-extended branch offset
- taken_count, not_taken_count  out  CNT_WIDTH  statistics
- stats_clr  in  1  synchronous clear of both counters

## Operation
- Decode uses the latched instruction. B: [31:26]=000101. BL: 100101. CBZ: [31:24]=10110100. CBNZ: 10110101. B.cond: 01010100. BR: [31:21]=11010110000. Anything else is illegal.
- Psel codes: HOLD=00, INC=01 (PC+4), REG=10 (PC<-register via SA), REL=11 (PC+4+K*4).
- NOP word in IDLE and after reset: all fields 0, so regW=ramW=0 and Psel=HOLD.
- State IDLE: on start, latch instruction and status, then go to EVAL. A start while busy is ignored.
- State EVAL:
  - CB*: SB=Rt[4:0], Fsel=PASS_B, regW=0, Psel=HOLD.
  - Taken is registered at the end of EVAL. CBZ is taken when alu_zero=1. CBNZ is taken when alu_zero=0. B, BL and BR are always taken.
  - B.cond is taken when cond[3:0]=instr[3:0] holds on the latched status. EQ Z, NE !Z, HS C, LO !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !(C&!Z), GE N==V, LT N!=V, GT !Z&(N==V), LE !GT. AL and NV are both taken.
  - Next state is LINK for BL, otherwise BRANCH.
- State LINK (BL only): DA=30, Dsel=PC_PLUS4, regW=1, Psel=HOLD. Next state is BRANCH.
- State BRANCH:
  - done=1, regW=ramW=0, PCsel=1.
  - Psel is REL if taken (REG for BR, with SA=instr[9:5]). Psel is INC if not taken or illegal.
  - Next state is IDLE.
- K: imm26 (instr[25:0]) sign-extended for B/BL; imm19 (instr[23:5]) sign-extended for CB* and B.cond; 0 otherwise. K is held stable from EVAL to BRANCH and is 0 in IDLE.
- Illegal instruction: not taken, illegal=1, no register or RAM write in any cycle.

## Timing
- Start is accepted at edge 0. EVAL runs in cycle 1. BRANCH (done) runs in cycle 2, or in cycle 3 for BL.
- The earliest next start is accepted in the cycle after done, so back-to-back throughput is one branch every 3 cycles (4 for BL).
- Reset values: state=IDLE, busy=done=branch_taken=illegal=0, controlWord=NOP, K=0, counters=0.
- Reset asserted mid-operation (any state) aborts immediately to IDLE with a NOP word. No partial link write is left asserted.
- status and instruction changing after acceptance have no effect.

## Configuration
- BRANCH_STATS_EN defined:
  - taken_count increments on each done with branch_taken=1 and legal.
  - not_taken_count increments on each done with branch_taken=0 and legal.
  - Both counters saturate at all-ones and do not wrap.
  - stats_clr zeroes both counters; if stats_clr and an increment happen in the same cycle, clear wins.
- BRANCH_STATS_EN undefined: both counter outputs are tied to 0, stats_clr is ignored, and no counter flops are present.

## Structure
- Package branch_pkg holds:
  - the state enum (IDLE, EVAL, LINK, BRANCH);
  - opcode match constants;
  - PSEL_*, DSEL_PC_PLUS4, FSEL_PASS_B;
  - a packed struct for the control-word fields;
  - the NOP constant.
- Sub-module branch_cond_eval is the combinational evaluation of cond[3:0] against status, giving a 1-bit taken result.

## Test plan
- CBZ X3, imm19=5, alu_zero=1: EVAL SB=3; done in cycle 2 with Psel=11, K=5, branch_taken=1.
- CBNZ, imm19=0x7FFFF, alu_zero=1: K=all-ones (-1), Psel=01, branch_taken=0.
- BL imm26=0x2000000: cycle 2 LINK with DA=30, regW=1; cycle 3 done with Psel=11 and K sign-extended negative.
- B.cond GT with status V=1 C=0 Z=0 N=1: taken. Same instruction with Z=1: not taken, Psel=01.
- instruction=0x8B000000 (ADD): done in cycle 2 with illegal=1, regW=0 throughout. With BRANCH_STATS_EN and CNT_WIDTH=2: 5 taken branches leave taken_count=3.
- Assert reset_n low during LINK: controlWord=0 and busy=0 immediately; a new start after release is accepted.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types, opcode constants and control-word helpers for the LEGv8 branch sequencer.
package branch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        LINK   = 2'd2,
        BRANCH = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        OP_B       = 3'd0,
        OP_BL      = 3'd1,
        OP_CBZ     = 3'd2,
        OP_CBNZ    = 3'd3,
        OP_BCOND   = 3'd4,
        OP_BR      = 3'd5,
        OP_ILLEGAL = 3'd6
    } op_t;

    localparam logic [5:0]  OPC_B     = 6'b000101;
    localparam logic [5:0]  OPC_BL    = 6'b100101;
    localparam logic [7:0]  OPC_CBZ   = 8'b10110100;
    localparam logic [7:0]  OPC_CBNZ  = 8'b10110101;
    localparam logic [7:0]  OPC_BCOND = 8'b01010100;
    localparam logic [10:0] OPC_BR    = 11'b11010110000;

    localparam logic [1:0] PSEL_HOLD     = 2'b00;
    localparam logic [1:0] PSEL_INC      = 2'b01;
    localparam logic [1:0] PSEL_REG      = 2'b10;
    localparam logic [1:0] PSEL_REL      = 2'b11;
    localparam logic [1:0] DSEL_PC_PLUS4 = 2'b10;
    localparam logic [4:0] FSEL_PASS_B   = 5'b00101;
    localparam logic [4:0] LINK_REG      = 5'd30;

    typedef struct packed {
        logic [1:0] psel;
        logic [4:0] da;
        logic [4:0] sa;
        logic [4:0] sb;
        logic [4:0] fsel;
        logic       reg_w;
        logic       ram_w;
        logic [1:0] dsel;
        logic       bsel;
        logic       pc_sel;
        logic       sl;
    } ctrl_word_t;

    localparam ctrl_word_t CW_NOP = ctrl_word_t'(29'd0);

    function automatic op_t decode_op(input logic [31:0] instr);
        op_t op;
        if (instr[31:26] == OPC_B) begin
            op = OP_B;
        end else if (instr[31:26] == OPC_BL) begin
            op = OP_BL;
        end else if (instr[31:24] == OPC_CBZ) begin
            op = OP_CBZ;
        end else if (instr[31:24] == OPC_CBNZ) begin
            op = OP_CBNZ;
        end else if (instr[31:24] == OPC_BCOND) begin
            op = OP_BCOND;
        end else if (instr[31:21] == OPC_BR) begin
            op = OP_BR;
        end else begin
            op = OP_ILLEGAL;
        end
        return op;
    endfunction

    // CB* routes Rt through the ALU so the zero flag reflects the live register value.
    function automatic ctrl_word_t cb_eval_word(input logic [4:0] rt);
        ctrl_word_t cw;
        cw      = CW_NOP;
        cw.sb   = rt;
        cw.fsel = FSEL_PASS_B;
        return cw;
    endfunction

    function automatic ctrl_word_t link_word();
        ctrl_word_t cw;
        cw       = CW_NOP;
        cw.da    = LINK_REG;
        cw.dsel  = DSEL_PC_PLUS4;
        cw.reg_w = 1'b1;
        return cw;
    endfunction

    function automatic ctrl_word_t branch_word(input op_t op, input logic taken, input logic [4:0] sa);
        ctrl_word_t cw;
        cw        = CW_NOP;
        cw.pc_sel = 1'b1;
        if (op == OP_ILLEGAL || !taken) begin
            cw.psel = PSEL_INC;
        end else if (op == OP_BR) begin
            cw.psel = PSEL_REG;
            cw.sa   = sa;
        end else begin
            cw.psel = PSEL_REL;
        end
        return cw;
    endfunction

endpackage

// File: rtl/branch_seq_unit_cond_eval.sv
// Combinational B.cond evaluation of cond[3:0] against the latched {V,C,Z,N} flags.
module branch_cond_eval (
    input  logic [3:0] cond,
    input  logic [3:0] status,
    output logic       taken
);

    logic v_s, c_s, z_s, n_s;
    logic ge_s, gt_s, hi_s;

    assign {v_s, c_s, z_s, n_s} = status;
    assign ge_s = (n_s == v_s);
    assign gt_s = !z_s && ge_s;
    assign hi_s = c_s && !z_s;

    // Condition-code decode; AL and NV are both unconditionally taken.
    always_comb begin
        case (cond)
            4'h0:    taken = z_s;
            4'h1:    taken = !z_s;
            4'h2:    taken = c_s;
            4'h3:    taken = !c_s;
            4'h4:    taken = n_s;
            4'h5:    taken = !n_s;
            4'h6:    taken = v_s;
            4'h7:    taken = !v_s;
            4'h8:    taken = hi_s;
            4'h9:    taken = !hi_s;
            4'hA:    taken = ge_s;
            4'hB:    taken = !ge_s;
            4'hC:    taken = gt_s;
            4'hD:    taken = !gt_s;
            4'hE:    taken = 1'b1;
            4'hF:    taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_seq_unit.sv
// Multi-cycle LEGv8 branch sequencer (CBZ/CBNZ/B.cond/B/BL/BR) driving the datapath control word.
// Optional statistics counters are built only when BRANCH_STATS_EN is defined.
module branch_seq_unit
    import branch_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [31:0]           instruction,
    input  logic [3:0]            status,
    input  logic                  alu_zero,
    input  logic                  stats_clr,
    output logic                  busy,
    output logic                  done,
    output logic                  branch_taken,
    output logic                  illegal,
    output logic [28:0]           controlWord,
    output logic [DATA_WIDTH-1:0] K,
    output logic [CNT_WIDTH-1:0]  taken_count,
    output logic [CNT_WIDTH-1:0]  not_taken_count
);

    state_t                state_r, state_next_s;
    op_t                   op_r, op_in_s;
    logic [3:0]            status_r, cond_r;
    logic [4:0]            sa_r;
    logic                  taken_r, taken_eval_s, cond_taken_s;
    logic                  accept_s;
    ctrl_word_t            cw_r, cw_next_s;
    logic [DATA_WIDTH-1:0] k_r, k_next_s, k_dec_s;
    logic                  busy_r, busy_next_s;
    logic                  done_r, done_next_s;
    logic                  taken_out_r, taken_out_next_s;
    logic                  illegal_r, illegal_next_s;

    assign op_in_s = decode_op(instruction);

    // Branch offset for the incoming instruction; captured into K as EVAL is entered.
    always_comb begin
        case (op_in_s)
            OP_B, OP_BL:
                k_dec_s = {{(DATA_WIDTH-26){instruction[25]}}, instruction[25:0]};
            OP_CBZ, OP_CBNZ, OP_BCOND:
                k_dec_s = {{(DATA_WIDTH-19){instruction[23]}}, instruction[23:5]};
            default:
                k_dec_s = {DATA_WIDTH{1'b0}};
        endcase
    end

    branch_cond_eval u_cond_eval (
        .cond   (cond_r),
        .status (status_r),
        .taken  (cond_taken_s)
    );

    // Branch resolution during EVAL; alu_zero carries the real Rt compare for CB*.
    always_comb begin
        case (op_r)
            OP_CBZ:             taken_eval_s = alu_zero;
            OP_CBNZ:            taken_eval_s = !alu_zero;
            OP_BCOND:           taken_eval_s = cond_taken_s;
            OP_B, OP_BL, OP_BR: taken_eval_s = 1'b1;
            default:            taken_eval_s = 1'b0;
        endcase
    end

    // Next-state and next-output logic; outputs are registered alongside the state they describe.
    always_comb begin
        state_next_s     = state_r;
        cw_next_s        = CW_NOP;
        k_next_s         = k_r;
        busy_next_s      = 1'b0;
        done_next_s      = 1'b0;
        taken_out_next_s = 1'b0;
        illegal_next_s   = 1'b0;
        accept_s         = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    accept_s     = 1'b1;
                    state_next_s = EVAL;
                    busy_next_s  = 1'b1;
                    k_next_s     = k_dec_s;
                    if (op_in_s == OP_CBZ || op_in_s == OP_CBNZ) begin
                        cw_next_s = cb_eval_word(instruction[4:0]);
                    end else begin
                        cw_next_s = CW_NOP;
                    end
                end else begin
                    k_next_s = {DATA_WIDTH{1'b0}};
                end
            end
            EVAL: begin
                busy_next_s = 1'b1;
                if (op_r == OP_BL) begin
                    state_next_s = LINK;
                    cw_next_s    = link_word();
                end else begin
                    state_next_s     = BRANCH;
                    done_next_s      = 1'b1;
                    taken_out_next_s = taken_eval_s;
                    illegal_next_s   = (op_r == OP_ILLEGAL);
                    cw_next_s        = branch_word(op_r, taken_eval_s, sa_r);
                end
            end
            LINK: begin
                state_next_s     = BRANCH;
                busy_next_s      = 1'b1;
                done_next_s      = 1'b1;
                taken_out_next_s = taken_r;
                cw_next_s        = branch_word(op_r, taken_r, sa_r);
            end
            BRANCH: begin
                state_next_s = IDLE;
                k_next_s     = {DATA_WIDTH{1'b0}};
            end
            default: begin
                state_next_s = IDLE;
                k_next_s     = {DATA_WIDTH{1'b0}};
            end
        endcase
    end

    // State register plus the instruction fields and flags latched on an accepted start.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            op_r     <= OP_ILLEGAL;
            status_r <= 4'd0;
            cond_r   <= 4'd0;
            sa_r     <= 5'd0;
            taken_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (accept_s) begin
                op_r     <= op_in_s;
                status_r <= status;
                cond_r   <= instruction[3:0];
                sa_r     <= instruction[9:5];
            end
            if (state_r == EVAL) begin
                taken_r <= taken_eval_s;
            end
        end
    end

    // Registered outputs; reset drops straight back to the NOP word.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cw_r        <= CW_NOP;
            k_r         <= {DATA_WIDTH{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            taken_out_r <= 1'b0;
            illegal_r   <= 1'b0;
        end else begin
            cw_r        <= cw_next_s;
            k_r         <= k_next_s;
            busy_r      <= busy_next_s;
            done_r      <= done_next_s;
            taken_out_r <= taken_out_next_s;
            illegal_r   <= illegal_next_s;
        end
    end

    assign controlWord  = cw_r;
    assign K            = k_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign branch_taken = taken_out_r;
    assign illegal      = illegal_r;

`ifdef BRANCH_STATS_EN
    logic [CNT_WIDTH-1:0] taken_cnt_r, not_taken_cnt_r;

    // Saturating outcome counters for legal branches; a clear in the same cycle wins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            taken_cnt_r     <= {CNT_WIDTH{1'b0}};
            not_taken_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (stats_clr) begin
            taken_cnt_r     <= {CNT_WIDTH{1'b0}};
            not_taken_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (done_r && !illegal_r) begin
            if (taken_out_r) begin
                if (taken_cnt_r != {CNT_WIDTH{1'b1}}) begin
                    taken_cnt_r <= taken_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end
            end else begin
                if (not_taken_cnt_r != {CNT_WIDTH{1'b1}}) begin
                    not_taken_cnt_r <= not_taken_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    assign taken_count     = taken_cnt_r;
    assign not_taken_count = not_taken_cnt_r;
`else
    logic unused_stats_clr_s;

    assign unused_stats_clr_s = stats_clr;
    assign taken_count        = {CNT_WIDTH{1'b0}};
    assign not_taken_count    = {CNT_WIDTH{1'b0}};
`endif

endmodule
